aes128_enc_ctrl: RTL and testbench

Sequencer for the AES-128 encryption datapath: accepts a block-start handshake, drives the key expansion unit's load/step strobes, and drives the round-datapath controls (initial AddRoundKey load, per-round enable, final-round flag). It presents the result with a valid/ready output handshake. It sits between the top-level I/O wrapper and the Key_Expansion and round datapath instances, one block in flight at a time.

---
 rtl/aes_pkg.sv | 16 +
 rtl/aes128_enc_ctrl.sv | 87 ++++++++
 tb/tb_aes128_enc_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 controller types and constants: sequencer state encoding,
// round count and round-index width.
package aes_pkg;

  localparam int AES_NUM_ROUNDS = 10;
  localparam int AES_RND_W      = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    FINAL,
    HOLD
  } aes_ctrl_state_t;

endpackage

// File: rtl/aes128_enc_ctrl.sv
// AES-128 encryption sequencer: drives key-expansion and round-datapath strobes
// for one block at a time. Optional block counter enabled by AES_CTRL_BLK_CNT_EN.
module aes128_enc_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int RND_W      = AES_RND_W
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  output logic             key_load,
  output logic             key_step,
  output logic             state_load,
  output logic             round_en,
  output logic             last_round,
  output logic [RND_W-1:0] rnd_idx,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef AES_CTRL_BLK_CNT_EN
  output logic [15:0]      blk_cnt,
`endif
  output logic             busy
);

  localparam logic [RND_W-1:0] LAST_STEP_RND = RND_W'(NUM_ROUNDS - 1);

  aes_ctrl_state_t state, state_nxt;
  logic [RND_W-1:0] rnd_idx_nxt;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rnd_idx <= '0;
    end else begin
      state   <= state_nxt;
      rnd_idx <= rnd_idx_nxt;
    end
  end

  // start_ready is the only output that looks at an input; strobes are pure state decodes.
  always_comb begin
    start_ready = (state == IDLE) || ((state == HOLD) && out_ready);
    key_load    = (state == LOAD);
    state_load  = (state == LOAD);
    key_step    = (state == ROUND);
    round_en    = (state == ROUND) || (state == FINAL);
    last_round  = (state == FINAL);
    out_valid   = (state == HOLD);
    busy        = (state == LOAD) || (state == ROUND) || (state == FINAL);
  end

  always_comb begin
    state_nxt   = state;
    rnd_idx_nxt = '0;
    case (state)
      IDLE: begin
        if (start_valid) state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt   = ROUND;
        rnd_idx_nxt = RND_W'(1);
      end
      ROUND: begin
        rnd_idx_nxt = rnd_idx + RND_W'(1);
        if (rnd_idx == LAST_STEP_RND) state_nxt = FINAL;
      end
      FINAL: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        // Taking a new block in the same cycle the result drains avoids a bubble.
        if (out_ready) state_nxt = start_valid ? LOAD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef AES_CTRL_BLK_CNT_EN
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) blk_cnt <= '0;
    else if ((state == HOLD) && out_ready) blk_cnt <= blk_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_aes128_enc_ctrl.sv
// Self-checking bench for aes128_enc_ctrl against a block-phase reference model.
module tb_aes128_enc_ctrl;

  logic       CLK = 1'b0;
  logic       rst_n;
  logic       start_valid;
  logic       start_ready;
  logic       key_load;
  logic       key_step;
  logic       state_load;
  logic       round_en;
  logic       last_round;
  logic [3:0] rnd_idx;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
`ifdef AES_CTRL_BLK_CNT_EN
  logic [15:0] blk_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: phase 0 = idle, 1 = load, 2..11 = rounds 1..10, 12 = result held.
  int phase = 0;
  int exp_blk = 0;

  always #5 CLK = ~CLK;

  aes128_enc_ctrl dut (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .key_load   (key_load),
    .key_step   (key_step),
    .state_load (state_load),
    .round_en   (round_en),
    .last_round (last_round),
    .rnd_idx    (rnd_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef AES_CTRL_BLK_CNT_EN
    .blk_cnt    (blk_cnt),
`endif
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h (phase %0d)", tag, obs, exp, phase);
  endtask

  task automatic check_outputs();
    chk("start_ready", 32'(start_ready), 32'((phase == 0) || (phase == 12 && out_ready)));
    chk("key_load",    32'(key_load),    32'(phase == 1));
    chk("state_load",  32'(state_load),  32'(phase == 1));
    chk("key_step",    32'(key_step),    32'(phase >= 2 && phase <= 10));
    chk("round_en",    32'(round_en),    32'(phase >= 2 && phase <= 11));
    chk("last_round",  32'(last_round),  32'(phase == 11));
    chk("rnd_idx",     32'(rnd_idx),     (phase >= 2 && phase <= 11) ? 32'(phase - 1) : 32'd0);
    chk("out_valid",   32'(out_valid),   32'(phase == 12));
    chk("busy",        32'(busy),        32'(phase >= 1 && phase <= 11));
`ifdef AES_CTRL_BLK_CNT_EN
    chk("blk_cnt",     32'(blk_cnt),     32'(exp_blk & 16'hFFFF));
`endif
  endtask

  // One clock cycle: drive inputs, check outputs, then advance the model across the edge.
  task automatic step(input logic sv, input logic ordy);
    @(negedge CLK);
    start_valid = sv;
    out_ready   = ordy;
    #1;
    check_outputs();
    if (rst_n) begin
      if (phase == 0) begin
        if (sv) phase = 1;
      end else if (phase < 12) begin
        phase = phase + 1;
      end else if (ordy) begin
        exp_blk = exp_blk + 1;
        phase   = sv ? 1 : 0;
      end
    end
  endtask

  int n;
  int nvalid;

  initial begin
    rst_n       = 1'b0;
    start_valid = 1'b0;
    out_ready   = 1'b0;
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    @(negedge CLK);
    rst_n = 1'b1;

    // Single block: latency from accept to first out_valid cycle.
    step(1'b1, 1'b0);
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b0);
      n = i;
      if (out_valid) break;
    end
    chk("latency", 32'(n), 32'd12);

    // Backpressure: result held while out_ready is low.
    repeat (5) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("idle_after_drain", 32'(start_ready), 32'd1);

    // Back-to-back blocks with continuous handshakes.
    nvalid = 0;
    for (int i = 0; i < 37; i++) begin
      step(1'b1, 1'b1);
      if (out_valid) nvalid++;
    end
    chk("b2b_blocks", 32'(nvalid), 32'd3);
    repeat (14) step(1'b0, 1'b1);

    // Start pulse while busy is ignored.
    nvalid = 0;
    step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b1);
      if (out_valid) nvalid++;
    end
    chk("busy_start_one_result", 32'(nvalid), 32'd1);

    // Asynchronous reset mid-round.
    step(1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    phase   = 0;
    exp_blk = 0;
    check_outputs();
    step(1'b0, 1'b0);
    @(negedge CLK);
    rst_n = 1'b1;
    step(1'b1, 1'b1);
    repeat (13) step(1'b0, 1'b1);

`ifdef AES_CTRL_BLK_CNT_EN
    chk("blk_cnt_after_reset_block", 32'(blk_cnt), 32'd1);
`endif

    // Randomized handshakes.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
